move_select_ctrl: RTL and testbench

//  Upstream input stage for the tic-tac-toe game FSM. Conditions five raw board buttons (up/down/left/

---
 rtl/move_select_ctrl_pkg.sv | 81 ++++++++
 rtl/move_select_ctrl_if.sv | 23 ++
 rtl/move_select_ctrl_btn.sv | 41 ++++
 rtl/move_select_ctrl.sv | 112 +++++++++++
 tb/tb_move_select_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/move_select_ctrl_pkg.sv
// Shared tic-tac-toe cursor definitions: grid mapping, centre position, auto-repeat axis state.
package move_select_ctrl_pkg;

  localparam int unsigned GRID = 3;
  localparam int unsigned CNT_W = 16;
  localparam logic [8:0] CENTRE_POS = 9'b000010000;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // drv_b records which of the axis' two buttons started the current hold.
  typedef struct packed {
    rpt_state_t       state;
    logic             drv_b;
    logic [CNT_W-1:0] cnt;
  } axis_t;

  function automatic logic [8:0] pos_onehot(input logic [1:0] row, input logic [1:0] col);
    logic [8:0] p;
    p = '0;
    if (row > 2'd2 || col > 2'd2) p = CENTRE_POS;
    else p[4'd8 - (4'(row) * 4'd3 + 4'(col))] = 1'b1;
    return p;
  endfunction

  function automatic logic [1:0] wrap_inc(input logic [1:0] x);
    return (x >= 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [1:0] wrap_dec(input logic [1:0] x);
    return (x == 2'd0) ? 2'd2 : x - 2'd1;
  endfunction

  function automatic axis_t axis_next(
    input  axis_t            cur,
    input  logic             pulse_a,
    input  logic             pulse_b,
    input  logic             level_a,
    input  logic             level_b,
    input  logic [CNT_W-1:0] dly_lim,
    input  logic [CNT_W-1:0] per_lim,
    output logic             step_a,
    output logic             step_b
  );
    axis_t            nxt;
    logic [CNT_W-1:0] lim;
    nxt    = cur;
    step_a = 1'b0;
    step_b = 1'b0;
    lim    = (cur.state == RPT_DELAY) ? dly_lim : per_lim;
    case (cur.state)
      RPT_IDLE: begin
        if (pulse_a ^ pulse_b) begin
          step_a    = pulse_a;
          step_b    = pulse_b;
          nxt.state = RPT_DELAY;
          nxt.drv_b = pulse_b;
          nxt.cnt   = '0;
        end
      end
      RPT_DELAY, RPT_REPEAT: begin
        if (!(cur.drv_b ? level_b : level_a)) begin
          nxt = '0;
        end else if (cur.cnt == lim) begin
          step_a    = ~cur.drv_b;
          step_b    = cur.drv_b;
          nxt.state = RPT_REPEAT;
          nxt.cnt   = '0;
        end else begin
          nxt.cnt = cur.cnt + 1'b1;
        end
      end
      default: nxt = '0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/move_select_ctrl_if.sv
// Board buttons, turn inputs and cursor/strobe outputs between the panel and the move selector.
interface move_select_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_place;
  logic       turnX;
  logic       turnO;
  logic [8:0] sel_pos;
  logic       buttonX;
  logic       buttonO;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_place, turnX, turnO,
    input  sel_pos, buttonX, buttonO
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_place, turnX, turnO,
    output sel_pos, buttonX, buttonO
  );
endinterface

// File: rtl/move_select_ctrl_btn.sv
// One raw button: 2-flop synchronizer, stability-count debounce, one-cycle rising-edge press pulse.
module btn_conditioner
  import move_select_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        level <= sync2;
        pulse <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_select_ctrl.sv
// Tic-tac-toe input stage: debounced nav buttons move a one-hot cursor with auto-repeat,
// place button issues a turn-routed single-cycle strobe with post-strobe lockout.
module move_select_ctrl #(
  parameter int unsigned DEB_CYCLES    = 16,
  parameter int unsigned REPEAT_DELAY  = 200,
  parameter int unsigned REPEAT_PERIOD = 50,
  parameter int unsigned LOCKOUT       = 32
) (
  input logic               clk,
  input logic               reset,
  move_select_ctrl_if.slave bus
);
  import move_select_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LIM = CNT_W'(REPEAT_PERIOD - 1);

  // Bit order: 4 up, 3 down, 2 left, 1 right.
  logic [4:1] nav_raw, nav_lvl, nav_pls;
  logic       place_pls;
  logic       place_level_unused;

  assign nav_raw = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};

  for (genvar g = 1; g <= 4; g++) begin : g_nav
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond (
      .clk  (clk),
      .reset(reset),
      .raw  (nav_raw[g]),
      .level(nav_lvl[g]),
      .pulse(nav_pls[g])
    );
  end

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_place (
    .clk  (clk),
    .reset(reset),
    .raw  (bus.btn_place),
    .level(place_level_unused),
    .pulse(place_pls)
  );

  axis_t            v_axis, v_next, h_axis, h_next;
  logic             step_up, step_dn, step_l, step_r, nav_move;
  logic [1:0]       row, col, row_n, col_n;
  logic [8:0]       sel_q;
  logic             strobe_x, strobe_o, place_defer;
  logic [CNT_W-1:0] lock_cnt;

  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    step_l  = 1'b0;
    step_r  = 1'b0;
    v_next  = axis_next(v_axis, nav_pls[4], nav_pls[3], nav_lvl[4], nav_lvl[3],
                        DLY_LIM, PER_LIM, step_up, step_dn);
    h_next  = axis_next(h_axis, nav_pls[2], nav_pls[1], nav_lvl[2], nav_lvl[1],
                        DLY_LIM, PER_LIM, step_l, step_r);
    nav_move = step_up | step_dn | step_l | step_r;
    row_n = row;
    col_n = col;
    if (row > 2'd2 || col > 2'd2) begin
      row_n = 2'd1;
      col_n = 2'd1;
    end else begin
      if (step_up) row_n = wrap_dec(row);
      else if (step_dn) row_n = wrap_inc(row);
      if (step_l) col_n = wrap_dec(col);
      else if (step_r) col_n = wrap_inc(col);
    end
  end

  // sel_pos is registered from the next row/col so it moves on the same edge as the cursor.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_axis      <= '0;
      h_axis      <= '0;
      row         <= 2'd1;
      col         <= 2'd1;
      sel_q       <= CENTRE_POS;
      strobe_x    <= 1'b0;
      strobe_o    <= 1'b0;
      place_defer <= 1'b0;
      lock_cnt    <= '0;
    end else begin
      v_axis      <= v_next;
      h_axis      <= h_next;
      row         <= row_n;
      col         <= col_n;
      sel_q       <= pos_onehot(row_n, col_n);
      strobe_x    <= 1'b0;
      strobe_o    <= 1'b0;
      place_defer <= 1'b0;
      if (lock_cnt != '0) lock_cnt <= lock_cnt - 1'b1;
      // A place request coinciding with a cursor step waits one clock so the strobe sees the new sel_pos.
      if ((place_pls | place_defer) && lock_cnt == '0) begin
        if (nav_move) begin
          place_defer <= 1'b1;
        end else if (bus.turnX ^ bus.turnO) begin
          strobe_x <= bus.turnX;
          strobe_o <= bus.turnO;
          lock_cnt <= CNT_W'(LOCKOUT);
        end
      end
    end
  end

  assign bus.sel_pos = sel_q;
  assign bus.buttonX = strobe_x;
  assign bus.buttonO = strobe_o;

endmodule

// File: tb/tb_move_select_ctrl.sv
// Directed bench for move_select_ctrl: tap vector table plus timing, auto-repeat, lockout and reset sequences.
module tb_move_select_ctrl;

  localparam int unsigned DEB = 16;
  localparam int unsigned TAP = DEB + 4;
  localparam int unsigned GAP = 60;
  localparam logic [8:0] CENTRE = 9'b000010000;
  localparam logic [4:0] U = 5'b10000, D = 5'b01000, L = 5'b00100, R = 5'b00010, P = 5'b00001;

  typedef struct {
    logic [4:0]  btns;
    int unsigned hold;
    logic        tx;
    logic        to;
    logic [8:0]  exp_sel;
    int unsigned exp_x;
    int unsigned exp_o;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  move_select_ctrl_if bus ();

  move_select_ctrl #(
    .DEB_CYCLES   (16),
    .REPEAT_DELAY (200),
    .REPEAT_PERIOD(50),
    .LOCKOUT      (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned xcnt = 0;
  int unsigned ocnt = 0;
  bit          mon_en = 1'b0;
  logic [8:0]  prev_sel;
  logic [8:0]  changes[$];
  vec_t        vecs[$];

  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (!$onehot(bus.sel_pos)) begin
        n_fail++;
        $display("FAIL onehot: sel_pos=%b, required exactly one bit set", bus.sel_pos);
      end
      n_checks++;
      if (bus.buttonX && bus.buttonO) begin
        n_fail++;
        $display("FAIL strobe_excl: buttonX=1 buttonO=1, required not both");
      end
      if (bus.buttonX) xcnt++;
      if (bus.buttonO) ocnt++;
      if (bus.sel_pos !== prev_sel) changes.push_back(bus.sel_pos);
      prev_sel = bus.sel_pos;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [4:0] m);
    {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_place} = m;
  endtask

  task automatic clear_mon();
    xcnt = 0;
    ocnt = 0;
    changes.delete();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [8:0] exp_seq[4];
    logic [8:0] got;

    set_btns('0);
    bus.turnX = 1'b0;
    bus.turnO = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    prev_sel = bus.sel_pos;
    mon_en = 1'b1;
    check("reset_sel", 32'(bus.sel_pos), 32'(CENTRE));
    check("reset_bx", 32'(bus.buttonX), 0);
    check("reset_bo", 32'(bus.buttonO), 0);

    clear_mon();
    tick(1000);
    check("idle_sel", 32'(bus.sel_pos), 32'(CENTRE));
    check("idle_x", xcnt, 0);
    check("idle_o", ocnt, 0);
    check("idle_moves", changes.size(), 0);

    // Right held DEB+10 clocks: step lands on edge DEB+3.
    clear_mon();
    set_btns(R);
    tick(DEB + 2);
    check("right_before", 32'(bus.sel_pos), 32'(CENTRE));
    tick(1);
    check("right_step", 32'(bus.sel_pos), 32'(9'b000001000));
    tick(7);
    set_btns('0);
    tick(GAP);
    check("right_final", 32'(bus.sel_pos), 32'(9'b000001000));
    check("right_moves", changes.size(), 1);

    vecs.push_back(vec_t'{U,     TAP,     1'b1, 1'b0, 9'b001000000, 0, 0});
    vecs.push_back(vec_t'{L,     TAP,     1'b1, 1'b0, 9'b010000000, 0, 0});
    vecs.push_back(vec_t'{L,     TAP,     1'b1, 1'b0, 9'b100000000, 0, 0});
    vecs.push_back(vec_t'{U,     TAP,     1'b1, 1'b0, 9'b000000100, 0, 0});
    vecs.push_back(vec_t'{D,     TAP,     1'b1, 1'b0, 9'b100000000, 0, 0});
    vecs.push_back(vec_t'{L,     TAP,     1'b1, 1'b0, 9'b001000000, 0, 0});
    vecs.push_back(vec_t'{R,     TAP,     1'b1, 1'b0, 9'b100000000, 0, 0});
    vecs.push_back(vec_t'{P,     TAP,     1'b1, 1'b0, 9'b100000000, 1, 0});
    vecs.push_back(vec_t'{P,     TAP,     1'b0, 1'b1, 9'b100000000, 0, 1});
    vecs.push_back(vec_t'{P,     TAP,     1'b1, 1'b1, 9'b100000000, 0, 0});
    vecs.push_back(vec_t'{P,     TAP,     1'b0, 1'b0, 9'b100000000, 0, 0});
    vecs.push_back(vec_t'{P,     5,       1'b1, 1'b0, 9'b100000000, 0, 0});
    vecs.push_back(vec_t'{U,     DEB - 1, 1'b1, 1'b0, 9'b100000000, 0, 0});
    vecs.push_back(vec_t'{U,     DEB,     1'b1, 1'b0, 9'b000000100, 0, 0});
    vecs.push_back(vec_t'{U | D, TAP,     1'b1, 1'b0, 9'b000000100, 0, 0});
    vecs.push_back(vec_t'{U | R, TAP,     1'b1, 1'b0, 9'b000010000, 0, 0});
    vecs.push_back(vec_t'{L | R, TAP,     1'b1, 1'b0, 9'b000010000, 0, 0});
    vecs.push_back(vec_t'{P | R, TAP,     1'b1, 1'b0, 9'b000001000, 1, 0});
    vecs.push_back(vec_t'{L,     TAP,     1'b1, 1'b0, 9'b000010000, 0, 0});

    foreach (vecs[i]) begin
      bus.turnX = vecs[i].tx;
      bus.turnO = vecs[i].to;
      clear_mon();
      set_btns(vecs[i].btns);
      tick(vecs[i].hold);
      set_btns('0);
      tick(GAP);
      check($sformatf("vec%0d_sel", i), 32'(bus.sel_pos), 32'(vecs[i].exp_sel));
      check($sformatf("vec%0d_x", i), xcnt, vecs[i].exp_x);
      check($sformatf("vec%0d_o", i), ocnt, vecs[i].exp_o);
    end

    // Down held from centre: initial step, delay step, then two period steps before release drops in.
    exp_seq = '{9'b000000010, 9'b010000000, 9'b000010000, 9'b000000010};
    clear_mon();
    set_btns(D);
    tick(200 + 2 * 50 + DEB + 20);
    set_btns('0);
    tick(GAP);
    check("rep_count", changes.size(), 4);
    for (int i = 0; i < 4; i++) begin
      got = (i < changes.size()) ? changes[i] : 9'h0;
      check($sformatf("rep_step%0d", i), 32'(got), 32'(exp_seq[i]));
    end

    // Second place press debounced inside the lockout window is discarded.
    bus.turnX = 1'b1;
    bus.turnO = 1'b0;
    clear_mon();
    set_btns(P);
    tick(DEB);
    set_btns('0);
    tick(DEB);
    set_btns(P);
    tick(20);
    set_btns('0);
    tick(80);
    check("lock_x", xcnt, 1);
    check("lock_o", ocnt, 0);
    clear_mon();
    set_btns(P);
    tick(TAP);
    set_btns('0);
    tick(GAP);
    check("after_lock_x", xcnt, 1);

    // Reset while buttons are held, then fresh debounce after release of reset.
    clear_mon();
    set_btns(L);
    tick(DEB + 3);
    check("pre_rst_sel", 32'(bus.sel_pos), 32'(9'b000000100));
    set_btns(L | P);
    tick(10);
    reset = 1'b1;
    clear_mon();
    tick(1);
    check("rst_sel", 32'(bus.sel_pos), 32'(CENTRE));
    tick(2);
    check("rst_x", xcnt, 0);
    check("rst_bx", 32'(bus.buttonX), 0);
    check("rst_bo", 32'(bus.buttonO), 0);
    clear_mon();
    reset = 1'b0;
    tick(DEB + 2);
    check("post_rst_hold", 32'(bus.sel_pos), 32'(CENTRE));
    tick(1);
    check("post_rst_step", 32'(bus.sel_pos), 32'(9'b000100000));
    tick(2);
    check("post_rst_x", xcnt, 1);
    check("post_rst_o", ocnt, 0);
    set_btns('0);
    tick(GAP);
    check("post_rst_final", 32'(bus.sel_pos), 32'(9'b000100000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
